// File: rtl/errmon_pkg.sv
// ============================================================================
// Module      : errmon_pkg
// Description : Shared constants for the error-monitor readout block.
//               Build option: ERRMON_PARITY_EN widens the bit counter for parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package errmon_pkg;

    localparam int EM_WORD_BITS   = 26;
    localparam int CLR_CYCLES_DEF = 2;

`ifdef ERRMON_PARITY_EN
    localparam int CNT_W = 6;
`else
    localparam int CNT_W = 5;
`endif

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_CLEAR   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int EM1_IDX  = 0;  localparam int EM2_IDX  = 1;  localparam int EM3_IDX  = 2;
    localparam int EM4_IDX  = 3;  localparam int EM5_IDX  = 4;  localparam int EM6_IDX  = 5;
    localparam int EM7_IDX  = 6;  localparam int EM8_IDX  = 7;  localparam int EM9_IDX  = 8;
    localparam int EM10_IDX = 9;  localparam int EM11_IDX = 10; localparam int EM12_IDX = 11;
    localparam int EM13_IDX = 12; localparam int EM14_IDX = 13; localparam int EM15_IDX = 14;
    localparam int EM16_IDX = 15; localparam int EM17_IDX = 16; localparam int EM18_IDX = 17;
    localparam int EM19_IDX = 18; localparam int EM20_IDX = 19; localparam int EM21_IDX = 20;
    localparam int EM22_IDX = 21; localparam int EM23_IDX = 22; localparam int EM24_IDX = 23;
    localparam int EM25_IDX = 24; localparam int EM26_IDX = 25;

endpackage

`default_nettype wire

// File: rtl/errmon_shreg.sv
// ============================================================================
// Module      : errmon_shreg
// Description : Snapshot register with indexed serial readout, bit counter and
//               last-bit flag. Build option: ERRMON_PARITY_EN appends odd parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module errmon_shreg
    import errmon_pkg::*;
#(
    parameter int WORD_BITS = EM_WORD_BITS,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic                 i_adv,
    input  logic [WORD_BITS-1:0] i_data,
    output logic [WORD_BITS-1:0] o_snap,
    output logic                 o_bit,
    output logic                 o_last
);

    localparam logic [CNT_W-1:0] c_top  = CNT_W'(WORD_BITS - 1);
`ifdef ERRMON_PARITY_EN
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WORD_BITS);
`else
    localparam logic [CNT_W-1:0] c_last = c_top;
`endif

    logic [WORD_BITS-1:0] snap_q, snap_d, w_shifted;
    logic [CNT_W-1:0]     cnt_q, cnt_d, w_idx;

    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        if (i_load) begin
            snap_d = i_data;
            cnt_d  = '0;
        end else if (i_adv && !o_last) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else if (i_en) begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

    // The snapshot stays intact so the top level can compare it against live inputs.
    assign w_idx     = (MSB_FIRST != 0) ? (c_top - cnt_q) : cnt_q;
    assign w_shifted = snap_q >> w_idx;
    assign o_last    = (cnt_q == c_last);
    assign o_snap    = snap_q;

`ifdef ERRMON_PARITY_EN
    assign o_bit = (cnt_q == c_last) ? ~^snap_q : w_shifted[0];
`else
    assign o_bit = w_shifted[0];
`endif

endmodule

`default_nettype wire

// File: rtl/errmon_readout.sv
// ============================================================================
// Module      : errmon_readout
// Description : Snapshots EM1..EM26 on read request, serializes them to the LVDC
//               and clears the latches. Build option: ERRMON_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module errmon_readout
    import errmon_pkg::*;
#(
    parameter int WORD_BITS  = EM_WORD_BITS,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 SIM_CLK,
    input  logic                 SIM_RST,
    input  logic                 V1,
    input  logic [WORD_BITS-1:0] EM_IN,
    input  logic                 RD_REQ,
    input  logic                 BIT_STB,
    output logic                 SER_OUT,
    output logic                 SER_VALID,
    output logic                 RD_BUSY,
    output logic                 RD_DONE,
    output logic                 EMRS_REQ,
    output logic                 LATE_ERR,
    output logic                 ANY_ERR
);

    localparam int               CLR_W      = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] c_clr_last = CLR_W'(CLR_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 late_q, late_d;
    logic                 late_err_q, late_err_d;
    logic                 any_err_q, any_err_d;
    logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                 w_load, w_adv, w_bit, w_last;
    logic [WORD_BITS-1:0] w_snap;

    errmon_shreg #(
        .WORD_BITS (WORD_BITS),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk    (SIM_CLK),
        .rst    (SIM_RST),
        .i_en   (V1),
        .i_load (w_load),
        .i_adv  (w_adv),
        .i_data (EM_IN),
        .o_snap (w_snap),
        .o_bit  (w_bit),
        .o_last (w_last)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        late_d     = late_q;
        late_err_d = late_err_q;
        clr_cnt_d  = clr_cnt_q;
        any_err_d  = |EM_IN;
        w_load     = 1'b0;
        w_adv      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RD_REQ || pending_q) begin
                    state_d   = ST_CAPTURE;
                    pending_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                w_load    = 1'b1;
                late_d    = 1'b0;
                clr_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                // A latch set after the snapshot would be wiped by EMRS without being read.
                if (|(EM_IN & ~w_snap)) late_d = 1'b1;
                if (BIT_STB) begin
                    w_adv = 1'b1;
                    if (w_last) state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (late_q) begin
                    late_err_d = 1'b1;
                    pending_d  = 1'b1;
                    state_d    = ST_DONE;
                end else if (clr_cnt_q == c_clr_last) begin
                    state_d    = ST_DONE;
                end else begin
                    clr_cnt_d  = clr_cnt_q + CLR_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (RD_REQ && (state_q != ST_IDLE)) pending_d = 1'b1;
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            late_q     <= 1'b0;
            late_err_q <= 1'b0;
            any_err_q  <= 1'b0;
            clr_cnt_q  <= '0;
        end else if (V1) begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            late_q     <= late_d;
            late_err_q <= late_err_d;
            any_err_q  <= any_err_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    assign SER_VALID = (state_q == ST_SHIFT);
    assign SER_OUT   = SER_VALID & w_bit;
    assign RD_BUSY   = (state_q != ST_IDLE);
    assign RD_DONE   = (state_q == ST_DONE);
    assign EMRS_REQ  = (state_q == ST_CLEAR) && !late_q;
    assign LATE_ERR  = late_err_q;
    assign ANY_ERR   = any_err_q;

endmodule

`default_nettype wire
